e3_result_fifo: RTL and testbench
=================================

E3_RESULT_FIFO -- requirements
Module: e3_result_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered results; legal values 2, 4 and 8.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: clr  input  1  synchronous flush of all entries.
REQ-006 Port: in_valid  input  1  upstream adder result present.
REQ-007 Port: in_ready  output  1  entry accepted on this edge when in_valid is also high.
REQ-008 Port: sum_e3  input  4  excess-3-biased sum from the adder stage.
REQ-009 Port: overflow  input  1  adder overflow flag for sum_e3.
REQ-010 Port: out_valid  output  1  head entry present.
REQ-011 Port: out_ready  input  1  downstream consumes the head on this edge.
REQ-012 Port: out_bin  output  4  head result with the bias removed.
REQ-013 Port: out_ovf  output  1  overflow flag of the head entry.
REQ-014 Port: level  output  4  current entry count, 0..DEPTH.
REQ-015 Port: ovf_cnt  output  8  count of accepted entries with overflow=1; present only with E3_OVF_CNT_EN.

Function
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready; the pushed entry is {overflow, sum_e3}.
REQ-017 Pop SHALL occur on a rising edge when out_valid && out_ready.
REQ-018 in_ready SHALL equal (level != DEPTH); there is no full bypass, so a push is refused when full even if a pop occurs in the same cycle.
REQ-019 out_valid SHALL equal (level != 0); there is no empty bypass, so a pushed entry first appears at the output one cycle after its push edge.
REQ-020 out_bin SHALL equal stored sum_e3 minus 4'd3 modulo 16 (for example, sum_e3 = 4'd1 gives 4'hE); out_ovf SHALL be the stored overflow bit.
REQ-021 out_bin and out_ovf SHALL be driven from registered storage at the read pointer; they are don't-care while out_valid = 0.
REQ-022 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 A simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-024 Pop while empty and push while full SHALL be ignored, with no change to state.
REQ-025 Data SHALL leave in push order.
REQ-026 clr SHALL have priority over push and pop: on the next edge level becomes 0 and both pointers become 0; ovf_cnt is unaffected.
REQ-027 Inputs sampled while in_valid = 0 SHALL have no effect.

Reset
REQ-028 While rst_n = 0, the block SHALL hold level = 0, both pointers = 0, out_valid = 0, in_ready = 1 and ovf_cnt = 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; the first push after deassertion SHALL be output first.
REQ-030 Storage array contents SHALL NOT be reset.

Configuration
REQ-031 Macro E3_OVF_CNT_EN defined: the ovf_cnt port and counter SHALL exist; the counter increments on each push with overflow = 1 and saturates at 8'hFF.
REQ-032 Macro E3_OVF_CNT_EN undefined: the ovf_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Push sum_e3 = 4'd5 with overflow = 0 into an empty FIFO -> the next cycle shows out_valid = 1, out_bin = 4'd2, out_ovf = 0, level = 1.
REQ-034 Push 5 entries back-to-back with DEPTH = 4 and out_ready = 0 -> in_ready = 0 after the 4th push, the 5th is held with level = 4, then drain yields the first 4 entries in order.
REQ-035 At level = 2, in_valid = 1 and out_ready = 1 for 6 cycles -> level stays 2, pointers wrap, and the output order matches the input order.
REQ-036 Push sum_e3 = 4'd1 and 4'd0 -> out_bin = 4'hE and 4'hD.
REQ-037 Assert rst_n = 0 asynchronously at level = 3 -> level = 0 and out_valid = 0 immediately; after release, push 4'd9 -> out_bin = 4'd6.
REQ-038 With E3_OVF_CNT_EN, 260 pushes with overflow = 1 -> ovf_cnt = 8'hFF; a clr pulse leaves it at 8'hFF.

Source files
------------

// File: rtl/e3_result_fifo.sv
// Result FIFO for the excess-3 adder: stores {overflow, sum_e3}, presents the head with the bias removed.
// Optional saturating overflow counter on ovf_cnt when E3_OVF_CNT_EN is defined.
module e3_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] sum_e3,
  input  logic       overflow,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_bin,
  output logic       out_ovf,
  output logic [3:0] level
`ifdef E3_OVF_CNT_EN
  ,
  output logic [7:0] ovf_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_level;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head;

  assign in_ready  = (r_level != 4'(DEPTH));
  assign out_valid = (r_level != 4'd0);
  // clr wins over both transfers, so neither pointer nor storage moves on a flush edge
  assign w_push    = in_valid && in_ready && !clr;
  assign w_pop     = out_valid && out_ready && !clr;
  assign level     = r_level;

  assign w_head  = r_mem[r_rd_ptr];
  assign out_bin = w_head[3:0] - 4'd3;
  assign out_ovf = w_head[4];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {overflow, sum_e3};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 4'd0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef E3_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  // Survives clr; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_push && overflow && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_e3_result_fifo.sv
// Directed self-checking bench for e3_result_fifo (DEPTH = 4).
// Overflow-counter checks are compiled in only when E3_OVF_CNT_EN is defined.
module tb_e3_result_fifo;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sum_e3;
  logic       overflow;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bin;
  logic       out_ovf;
  logic [3:0] level;
`ifdef E3_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  e3_result_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_e3    (sum_e3),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_ovf   (out_ovf),
    .level     (level)
`ifdef E3_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic ov);
    in_valid = 1'b1;
    sum_e3   = s;
    overflow = ov;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    sum_e3    = 4'd0;
    overflow  = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_level", level, 8'd0);
    check("rst_out_valid", out_valid, 8'd0);
    check("rst_in_ready", in_ready, 8'd1);
`ifdef E3_OVF_CNT_EN
    check("rst_ovf_cnt", ovf_cnt, 8'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Single push: 5 -> 2
    push(4'd5, 1'b0);
    check("p1_out_valid", out_valid, 8'd1);
    check("p1_out_bin", out_bin, 8'd2);
    check("p1_out_ovf", out_ovf, 8'd0);
    check("p1_level", level, 8'd1);
    pop();
    check("p1_pop_level", level, 8'd0);
    check("p1_pop_out_valid", out_valid, 8'd0);

    // Bias wrap: 1 -> E, 0 -> D (second with overflow)
    push(4'd1, 1'b0);
    push(4'd0, 1'b1);
    check("wrap_level", level, 8'd2);
    check("wrap_bin0", out_bin, 8'hE);
    check("wrap_ovf0", out_ovf, 8'd0);
    pop();
    check("wrap_bin1", out_bin, 8'hD);
    check("wrap_ovf1", out_ovf, 8'd1);
    pop();
    check("wrap_empty", level, 8'd0);

    // Pop while empty is ignored
    pop();
    check("empty_pop_level", level, 8'd0);
    check("empty_pop_in_ready", in_ready, 8'd1);

    // Fill past full with out_ready low: bins 0..4 (sums 3..7)
    for (int i = 0; i < 5; i++) begin
      check("fill_in_ready", in_ready, (i < 4) ? 8'd1 : 8'd0);
      push(4'(i + 3), 1'b0);
    end
    check("full_level", level, 8'd4);
    check("full_in_ready", in_ready, 8'd0);
    check("full_head", out_bin, 8'd0);
    // Full with simultaneous pop: push refused, pop taken
    in_valid  = 1'b1;
    sum_e3    = 4'hC;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("full_pushpop_level", level, 8'd3);
    for (int i = 1; i < 4; i++) begin
      check("drain_valid", out_valid, 8'd1);
      check("drain_bin", out_bin, 8'(i));
      pop();
    end
    check("drain_level", level, 8'd0);
    check("drain_out_valid", out_valid, 8'd0);

    // Steady push+pop at level 2 across pointer wrap; bins 10,11 then 12..17 mod 16
    push(4'd13, 1'b0);
    push(4'd14, 1'b0);
    check("steady_pre_level", level, 8'd2);
    for (int k = 0; k < 6; k++) begin
      in_valid  = 1'b1;
      sum_e3    = 4'((12 + k + 3) & 15);
      overflow  = k[0];
      out_ready = 1'b1;
      check("steady_bin", out_bin, 8'((10 + k) & 15));
      tick();
      check("steady_level", level, 8'd2);
    end
    in_valid = 1'b0;
    check("steady_tail0", out_bin, 8'd0);
    check("steady_tail0_ovf", out_ovf, 8'd0);
    tick();
    check("steady_tail1", out_bin, 8'd1);
    check("steady_tail1_ovf", out_ovf, 8'd1);
    tick();
    out_ready = 1'b0;
    check("steady_end_level", level, 8'd0);

    // clr beats concurrent push and pop
    push(4'd3, 1'b0);
    push(4'd4, 1'b0);
    push(4'd5, 1'b0);
    clr       = 1'b1;
    in_valid  = 1'b1;
    sum_e3    = 4'd8;
    out_ready = 1'b1;
    tick();
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clr_level", level, 8'd0);
    check("clr_out_valid", out_valid, 8'd0);
    push(4'd7, 1'b0);
    check("clr_next_bin", out_bin, 8'd4);
    check("clr_next_level", level, 8'd1);
    pop();

    // Asynchronous reset mid-cycle at level 3
    push(4'd4, 1'b1);
    push(4'd5, 1'b0);
    push(4'd6, 1'b0);
    check("pre_rst_level", level, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 8'd0);
    check("async_rst_out_valid", out_valid, 8'd0);
    check("async_rst_in_ready", in_ready, 8'd1);
    tick();
    rst_n = 1'b1;
    push(4'd9, 1'b0);
    check("post_rst_bin", out_bin, 8'd6);
    check("post_rst_level", level, 8'd1);
    pop();

`ifdef E3_OVF_CNT_EN
    check("ovf_cnt_after_rst", ovf_cnt, 8'd0);
    in_valid  = 1'b1;
    overflow  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      sum_e3 = 4'(i);
      tick();
      if (i == 9) check("ovf_cnt_10", ovf_cnt, 8'd10);
    end
    in_valid  = 1'b0;
    overflow  = 1'b0;
    tick();
    out_ready = 1'b0;
    check("ovf_cnt_sat", ovf_cnt, 8'hFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovf_cnt_after_clr", ovf_cnt, 8'hFF);
    check("ovf_clr_level", level, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
